uart_program_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a program image over a UART line and writes it into instruction memory as 32-bit words.
- Holds the processor core in reset via core_resetn until the image is fully and correctly loaded, then releases it.
- Sits between the board UART pin and the instruction memory write port, beside the processor top.

---
 rtl/uart_program_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: receives a length-prefixed image over 8N1 serial and writes 32-bit words to imem.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_resetn,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;
    localparam ld_state_t L_END = L_CSUM;
`else
    typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} ld_state_t;
    localparam ld_state_t L_END = L_DONE;
`endif

    logic          r_rx_s1;
    logic          r_rx_s2;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_rx_shift;
    logic          r_byte_valid;
    logic          r_frame_err;

    ld_state_t     r_state;
    logic [7:0]    r_len_lo;
    logic [15:0]   r_len;
    logic [23:0]   r_word;
    logic [1:0]    r_byte_idx;
    logic          r_imem_we;
    logic [31:0]   r_imem_addr;
    logic [31:0]   r_imem_wdata;
    logic          r_core_resetn;
    logic          r_load_busy;
    logic          r_load_done;
    logic          r_load_error;
    logic [15:0]   r_words_loaded;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic [15:0]   w_len;
    logic          w_last_word;

    assign w_len       = {r_rx_shift, r_len_lo};
    assign w_last_word = (r_words_loaded == r_len - 16'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // Start bit is re-checked mid-bit so short low glitches are rejected as false starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_state   <= RX_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_baud_cnt <= HALF_M1;
                    end
                end
                RX_START: begin
                    if (r_baud_cnt == '0) begin
                        if (r_rx_s2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_DATA;
                            r_baud_cnt <= FULL_M1;
                            r_bit_idx  <= '0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_baud_cnt == '0) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_baud_cnt <= FULL_M1;
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_baud_cnt == '0) begin
                        r_byte_valid <= r_rx_s2;
                        r_frame_err  <= !r_rx_s2;
                        r_rx_state   <= RX_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= L_LEN0;
            r_len_lo       <= '0;
            r_len          <= '0;
            r_word         <= '0;
            r_byte_idx     <= '0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_core_resetn  <= 1'b0;
            r_load_busy    <= 1'b0;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum         <= '0;
`endif
        end else begin
            r_imem_we <= 1'b0;
            // A framing error anywhere before completion poisons the whole image.
            if (r_frame_err && r_state != L_DONE && r_state != L_ERR) begin
                r_state <= L_ERR;
            end else begin
                case (r_state)
                    L_LEN0: begin
                        if (r_byte_valid) begin
                            r_len_lo    <= r_rx_shift;
                            r_load_busy <= 1'b1;
                            r_state     <= L_LEN1;
                        end
                    end
                    L_LEN1: begin
                        if (r_byte_valid) begin
                            r_len      <= w_len;
                            r_byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                            if ({1'b0, w_len} > MAX_WORDS) begin
                                r_state <= L_ERR;
                            end else if (w_len == 16'd0) begin
                                r_state <= L_END;
                            end else begin
                                r_state <= L_DATA;
                            end
                        end
                    end
                    L_DATA: begin
                        if (r_byte_valid) begin
                            r_word     <= {r_rx_shift, r_word[23:8]};
                            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= r_csum ^ r_rx_shift;
`endif
                            if (r_byte_idx == 2'd3) begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= {14'd0, r_words_loaded, 2'b00};
                                r_imem_wdata <= {r_rx_shift, r_word};
                                if (r_words_loaded != 16'hFFFF) begin
                                    r_words_loaded <= r_words_loaded + 16'd1;
                                end
                                if (w_last_word) begin
                                    r_state <= L_END;
                                end
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    L_CSUM: begin
                        if (r_byte_valid) begin
                            r_state <= (r_rx_shift == r_csum) ? L_DONE : L_ERR;
                        end
                    end
`endif
                    L_DONE: begin
                        r_core_resetn <= 1'b1;
                        r_load_done   <= 1'b1;
                        r_load_busy   <= 1'b0;
                    end
                    L_ERR: begin
                        r_load_error  <= 1'b1;
                        r_load_busy   <= 1'b0;
                        r_core_resetn <= 1'b0;
                    end
                    default: r_state <= L_ERR;
                endcase
            end
        end
    end

    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign core_resetn  = r_core_resetn;
    assign load_busy    = r_load_busy;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_words_loaded;
endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader: serial images against a byte-level model of the image format.
// Works in both builds; the checksum byte is always appended and the model decides whether it matters.
module tb_uart_program_loader;
    localparam int CPB = 8;
    localparam int AW  = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_resetn;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] cap[$];
    logic [63:0] exp_wr[$];
    bit          exp_done;
    bit          exp_err;
    bit          exp_busy;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_resetn(core_resetn), .load_busy(load_busy), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && imem_we) cap.push_back({imem_addr, imem_wdata});
    end

    // Byte-level reference: walks the image as the format describes it.
    task automatic model(input logic [7:0] img[$], input int bad);
        int n;
        int k;
        logic [7:0]  x;
        logic [31:0] w;
        exp_wr.delete();
        exp_done = 0; exp_err = 0; exp_busy = 0;
        n = 0; x = 8'h00; w = 32'h0;
        for (int i = 0; i < img.size(); i++) begin
            if (exp_done || exp_err) break;
            if (i == bad) begin exp_err = 1; break; end
            exp_busy = 1;
            if (i == 0) begin
                n = int'(img[0]);
            end else if (i == 1) begin
                n = n + 256 * int'(img[1]);
                if (n > (1 << AW)) exp_err = 1;
                else if (n == 0 && !CSUM) exp_done = 1;
            end else if (i < 2 + 4 * n) begin
                k = i - 2;
                x = x ^ img[i];
                w[8 * (k % 4) +: 8] = img[i];
                if (k % 4 == 3) exp_wr.push_back({32'((k / 4) * 4), w});
                if (k == 4 * n - 1 && !CSUM) exp_done = 1;
            end else begin
                if (img[i] == x) exp_done = 1;
                else exp_err = 1;
            end
        end
        if (exp_done || exp_err) exp_busy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        cap.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_image(input logic [7:0] img[$], input int bad);
        for (int i = 0; i < img.size(); i++) send_byte(img[i], i == bad);
        repeat (4 * CPB) @(negedge clk);
    endtask

    function automatic logic [7:0] payload_xor(input logic [7:0] img[$]);
        logic [7:0] x = 8'h00;
        for (int i = 2; i < img.size(); i++) x = x ^ img[i];
        return x;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_checks++; if (imem_we !== 1'b0)       begin n_fail++; $display("FAIL reset imem_we got %b want 0", imem_we); end
        n_checks++; if (imem_addr !== 32'h0)    begin n_fail++; $display("FAIL reset imem_addr got %h want 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'h0)   begin n_fail++; $display("FAIL reset imem_wdata got %h want 0", imem_wdata); end
        n_checks++; if (core_resetn !== 1'b0)   begin n_fail++; $display("FAIL reset core_resetn got %b want 0", core_resetn); end
        n_checks++; if (load_busy !== 1'b0)     begin n_fail++; $display("FAIL reset load_busy got %b want 0", load_busy); end
        n_checks++; if (load_done !== 1'b0)     begin n_fail++; $display("FAIL reset load_done got %b want 0", load_done); end
        n_checks++; if (load_error !== 1'b0)    begin n_fail++; $display("FAIL reset load_error got %b want 0", load_error); end
        n_checks++; if (words_loaded !== 16'h0) begin n_fail++; $display("FAIL reset words_loaded got %0d want 0", words_loaded); end
        do_reset();
        repeat (3 * CPB) @(negedge clk);
        n_checks++; if (load_busy !== 1'b0 || core_resetn !== 1'b0 || cap.size() != 0) begin
            n_fail++; $display("FAIL idle_after_reset busy=%b core_resetn=%b writes=%0d want 0 0 0", load_busy, core_resetn, cap.size());
        end
    endtask

    // Runs one image from reset, optionally preceded by a 2-cycle low glitch, and compares everything.
    task automatic test_image(input string name, input logic [7:0] img[$], input int bad, input bit glitch);
        do_reset();
        if (glitch) begin
            uart_rx = 1'b0;
            repeat (2) @(negedge clk);
            uart_rx = 1'b1;
            repeat (3 * CPB) @(negedge clk);
            n_checks++; if (load_busy !== 1'b0 || words_loaded !== 16'h0 || cap.size() != 0 || load_error !== 1'b0) begin
                n_fail++; $display("FAIL %s glitch busy=%b words=%0d writes=%0d err=%b want all 0", name, load_busy, words_loaded, cap.size(), load_error);
            end
        end
        send_image(img, bad);
        model(img, bad);
        n_checks++; if (cap.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL %s write_count got %0d want %0d", name, cap.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < cap.size(); i++) begin
            n_checks++; if (cap[i] !== exp_wr[i]) begin
                n_fail++; $display("FAIL %s write[%0d] addr/data got %h want %h", name, i, cap[i], exp_wr[i]);
            end
        end
        n_checks++; if (load_done !== exp_done)    begin n_fail++; $display("FAIL %s load_done got %b want %b", name, load_done, exp_done); end
        n_checks++; if (load_error !== exp_err)    begin n_fail++; $display("FAIL %s load_error got %b want %b", name, load_error, exp_err); end
        n_checks++; if (core_resetn !== exp_done)  begin n_fail++; $display("FAIL %s core_resetn got %b want %b", name, core_resetn, exp_done); end
        n_checks++; if (load_busy !== exp_busy)    begin n_fail++; $display("FAIL %s load_busy got %b want %b", name, load_busy, exp_busy); end
        n_checks++; if (words_loaded !== 16'(exp_wr.size())) begin
            n_fail++; $display("FAIL %s words_loaded got %0d want %0d", name, words_loaded, exp_wr.size());
        end
    endtask

    task automatic test_directed();
        logic [7:0] img[$];
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        test_image("case1", img, -1, 1'b0);
        test_image("case1_glitch", img, -1, 1'b1);
        img.push_back(8'h01); img.push_back(8'h00); img.push_back(8'hAA);
        test_image("done_ignores_extra", img, -1, 1'b0);
        img = '{8'h00, 8'h00, 8'h00};
        test_image("case2_empty", img, -1, 1'b0);
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90,
                8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        test_image("case3_frame_err", img, 7, 1'b0);
        test_image("len_frame_err", img, 1, 1'b0);
        img = '{8'h11, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        test_image("case4_overflow", img, -1, 1'b0);
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        test_image("case6_bad_csum", img, -1, 1'b0);
        img = '{8'h10, 8'h00};
        for (int i = 0; i < 64; i++) img.push_back(8'($urandom));
        img.push_back(payload_xor(img));
        test_image("max_words", img, -1, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [7:0] img[$];
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
        repeat (2 * CPB) @(negedge clk);
        n_checks++; if (cap.size() != 1) begin n_fail++; $display("FAIL mid_reset first_word writes got %0d want 1", cap.size()); end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++; if (words_loaded !== 16'h0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 || load_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset clear words=%0d addr=%h data=%h busy=%b want 0", words_loaded, imem_addr, imem_wdata, load_busy);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cap.delete();
        repeat (2) @(negedge clk);
        send_image(img, -1);
        model(img, -1);
        n_checks++; if (cap.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL mid_reset write_count got %0d want %0d", cap.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < cap.size(); i++) begin
            n_checks++; if (cap[i] !== exp_wr[i]) begin
                n_fail++; $display("FAIL mid_reset write[%0d] got %h want %h", i, cap[i], exp_wr[i]);
            end
        end
        n_checks++; if (load_done !== 1'b1 || core_resetn !== 1'b1 || words_loaded !== 16'd2) begin
            n_fail++; $display("FAIL mid_reset final done=%b core_resetn=%b words=%0d want 1 1 2", load_done, core_resetn, words_loaded);
        end
    endtask

    task automatic test_random();
        logic [7:0] img[$];
        logic [7:0] x;
        int n;
        int plen;
        int bad;
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(0, 8));
            if ($urandom_range(0, 4) == 0) n = 17 + int'($urandom_range(0, 3));
            img.delete();
            img.push_back(n[7:0]);
            img.push_back(n[15:8]);
            plen = (n > 16) ? 4 : 4 * n;
            for (int i = 0; i < plen; i++) img.push_back(8'($urandom));
            x = payload_xor(img);
            if ($urandom_range(0, 3) == 0) x = x ^ 8'h01;
            img.push_back(x);
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
            test_image($sformatf("rand%0d", r), img, bad, (r % 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
